// File: rtl/reg_native_if_arb_pkg.sv
// Shared types for the native register-bus arbiter: FSM state encoding and watchdog sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_native_if_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never narrower than 1 bit
    // so a disabled watchdog (timeout 0) still yields a legal vector.
    function automatic int wdog_cnt_width(input int timeout_cycles);
        int w;
        w = $clog2(timeout_cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_native_if_arbiter_rr.sv
// Round-robin picker: first asserted req strictly after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; grant_vld low when no request is asserted.
//
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index granted most recently (lowest priority this round)
//   grant      - one-hot grant
//   grant_idx  - binary index of grant
//   grant_vld  - any request granted
module rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int IDX_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_MST-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        // Offsets 1..NUM_MST visit every requester once, ending on last_grant itself.
        for (int k = 1; k <= NUM_MST; k++) begin
            sum = {1'b0, last_grant} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_MST)) begin
                sum = sum - (IDX_W + 1)'(NUM_MST);
            end
            idx = sum[IDX_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_native_if_arbiter.sv
// Shares one downstream native register port among NUM_MST requesters, one transaction at a time.
// Latency: request -> s_req_vld 2 cycles uncontended; s_ack_vld -> m_ack_vld 1 cycle.
// Backpressure: one-deep slot per requester; repeat requests while pending are dropped; watchdog errors a hung ack.
//
// Ports:
//   native_clk / native_rst_n     - clock, synchronous active-low reset
//   m_req_vld/m_addr/m_wr_en/m_rd_en/m_wr_data - packed upstream requests, requester i at slice i
//   m_ack_vld/m_err/m_rd_data     - upstream response, one-hot ack
//   s_req_vld/s_addr/s_wr_en/s_rd_en/s_wr_data - downstream request
//   s_ack_vld/s_err/s_rd_data     - downstream response
//   busy                          - any slot pending or a transaction in flight
module reg_native_if_arbiter
    import reg_native_if_arb_pkg::*;
#(
    parameter int NUM_MST        = 4,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                native_clk,
    input  logic                                native_rst_n,
    input  logic [NUM_MST-1:0]                  m_req_vld,
    input  logic [NUM_MST*BUS_ADDR_WIDTH-1:0]   m_addr,
    input  logic [NUM_MST-1:0]                  m_wr_en,
    input  logic [NUM_MST-1:0]                  m_rd_en,
    input  logic [NUM_MST*BUS_DATA_WIDTH-1:0]   m_wr_data,
    output logic [NUM_MST-1:0]                  m_ack_vld,
    output logic                                m_err,
    output logic [BUS_DATA_WIDTH-1:0]           m_rd_data,
    output logic                                s_req_vld,
    output logic [BUS_ADDR_WIDTH-1:0]           s_addr,
    output logic                                s_wr_en,
    output logic                                s_rd_en,
    output logic [BUS_DATA_WIDTH-1:0]           s_wr_data,
    input  logic                                s_ack_vld,
    input  logic                                s_err,
    input  logic [BUS_DATA_WIDTH-1:0]           s_rd_data,
    output logic                                busy
);

    localparam int IDX_W     = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W     = wdog_cnt_width(TIMEOUT_CYCLES);
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);
    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 0);
    // Pointer starts on the last index so requester 0 wins the first round.
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_MST - 1);

    arb_state_t state_q, state_d;

    logic [NUM_MST-1:0]        pending_q;
    logic [NUM_MST-1:0]        pending_d;
    logic [NUM_MST-1:0]        capture;
    logic [NUM_MST-1:0]        ack_mask;
    logic [NUM_MST-1:0]        grant_oh_q;
    logic [IDX_W-1:0]          grant_idx_q;
    logic [IDX_W-1:0]          ptr_q;
    logic [CNT_W-1:0]          wdog_cnt_q;
    logic                      wdog_expire;
    logic                      resp_err_q;

    logic [NUM_MST-1:0]        arb_grant;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_vld;

    logic [BUS_ADDR_WIDTH-1:0] slot_addr  [NUM_MST];
    logic                      slot_wr    [NUM_MST];
    logic                      slot_rd    [NUM_MST];
    logic [BUS_DATA_WIDTH-1:0] slot_wdata [NUM_MST];

    rr_arbiter #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (pending_q),
        .last_grant (ptr_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    // A slot being acked this cycle may be refilled in the same cycle; otherwise a
    // pending slot ignores further requests from its owner.
    assign ack_mask    = (state_q == ST_RESP) ? grant_oh_q : '0;
    assign capture     = m_req_vld & (~pending_q | ack_mask);
    assign pending_d   = (pending_q & ~ack_mask) | capture;
    assign wdog_expire = WDOG_EN && (wdog_cnt_q == TO_LAST);

    assign s_req_vld = (state_q == ST_ISSUE);
    assign m_ack_vld = ack_mask;
    assign m_err     = (state_q == ST_RESP) && resp_err_q;
    assign busy      = (|pending_q) || (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arb_vld) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (s_ack_vld || wdog_expire) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Slot payload carries no reset: it is only observed once pending marks it valid.
    always_ff @(posedge native_clk) begin
        for (int i = 0; i < NUM_MST; i++) begin
            if (capture[i]) begin
                slot_addr[i]  <= m_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
                slot_wr[i]    <= m_wr_en[i];
                slot_rd[i]    <= m_rd_en[i];
                slot_wdata[i] <= m_wr_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge native_clk) begin
        if (!native_rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            ptr_q       <= PTR_RST;
            wdog_cnt_q  <= '0;
            resp_err_q  <= 1'b0;
            m_rd_data   <= '0;
            s_addr      <= '0;
            s_wr_en     <= 1'b0;
            s_rd_en     <= 1'b0;
            s_wr_data   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;

            if (state_q == ST_IDLE && arb_vld) begin
                grant_oh_q  <= arb_grant;
                grant_idx_q <= arb_idx;
                s_addr      <= slot_addr[arb_idx];
                s_wr_en     <= slot_wr[arb_idx];
                s_rd_en     <= slot_rd[arb_idx];
                s_wr_data   <= slot_wdata[arb_idx];
            end

            if (state_q == ST_ISSUE) begin
                ptr_q <= grant_idx_q;
            end

            if (state_q == ST_WAIT && WDOG_EN) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end else begin
                wdog_cnt_q <= '0;
            end

            // A real ack in the expiry cycle takes precedence over the timeout error.
            if (state_q == ST_WAIT) begin
                if (s_ack_vld) begin
                    resp_err_q <= s_err;
                    m_rd_data  <= s_rd_data;
                end else if (wdog_expire) begin
                    resp_err_q <= 1'b1;
                    m_rd_data  <= '0;
                end
            end
        end
    end

endmodule
